// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle on magnitudes; signs are reapplied on the way out.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [1:0]      DivOp,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] DivRes
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [XLEN-1:0]   r_q;
  logic [XLEN-1:0]   r_r;
  logic [XLEN-1:0]   r_d;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg_a;
  logic              r_neg_b;
  logic              r_want_rem;
  logic [XLEN-1:0]   r_divres;

  logic              w_signed;
  logic              w_neg_a;
  logic              w_neg_b;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_trial;
  logic              w_ge;
  logic [XLEN-1:0]   w_r_step;
  logic [XLEN-1:0]   w_q_step;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic              w_last;

  // Operand conditioning at acceptance; |most-negative| wraps to itself and is used as unsigned.
  assign w_signed   = ~DivOp[0];
  assign w_neg_a    = w_signed & A[XLEN-1];
  assign w_neg_b    = w_signed & B[XLEN-1];
  assign w_abs_a    = w_neg_a ? -A : A;
  assign w_abs_b    = w_neg_b ? -B : B;
  assign w_div_zero = (B == '0);
  assign w_ovf      = w_signed && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
  assign w_special  = w_div_zero | w_ovf;
  assign w_special_res = w_div_zero ? (DivOp[1] ? A : '1)
                                    : (DivOp[1] ? '0 : A);

  // Restoring step: R < D always holds, so the XLEN+1-bit trial sign is exact.
  assign w_shift  = {r_r, r_q[XLEN-1]};
  assign w_trial  = w_shift - {1'b0, r_d};
  assign w_ge     = ~w_trial[XLEN];
  assign w_r_step = w_ge ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_q_step = {r_q[XLEN-2:0], w_ge};
  assign w_quot   = (r_neg_a ^ r_neg_b) ? -w_q_step : w_q_step;
  assign w_rem    = r_neg_a ? -w_r_step : w_r_step;
  assign w_last   = (r_cnt == CNT_W'(XLEN-1));

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != IDLE);
    done         = (r_state == FIN);
    case (r_state)
      IDLE:    if (start) w_state_next = w_special ? FIN : CALC;
      CALC:    if (w_last) w_state_next = FIN;
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q        <= '0;
      r_r        <= '0;
      r_d        <= '0;
      r_cnt      <= '0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_want_rem <= 1'b0;
      r_divres   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_q        <= w_abs_a;
            r_d        <= w_abs_b;
            r_r        <= '0;
            r_cnt      <= '0;
            r_neg_a    <= w_neg_a;
            r_neg_b    <= w_neg_b;
            r_want_rem <= DivOp[1];
            if (w_special) r_divres <= w_special_res;
          end
        end
        CALC: begin
          r_q   <= w_q_step;
          r_r   <= w_r_step;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_divres <= r_want_rem ? w_rem : w_quot;
        end
        default: ;
      endcase
    end
  end

  assign DivRes = r_divres;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases plus randomized start traffic
// compared every cycle against a countdown/arithmetic reference model.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  DivOp;
  logic        busy;
  logic        done;
  logic [31:0] DivRes;

  int n_pass;
  int n_total;

  div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (A),
    .B      (B),
    .DivOp  (DivOp),
    .busy   (busy),
    .done   (done),
    .DivRes (DivRes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Architectural result from RISC-V M rules using native integer division.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    case (op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Model: cycles left until the unit is idle again; done on the last one.
  int          m_left;
  logic [31:0] m_pending;
  logic [31:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left    = 0;
      m_res     = 32'd0;
      m_pending = 32'd0;
    end else if (m_left > 0) begin
      if (m_left == 1) m_res = m_pending;
      m_left = m_left - 1;
    end else if (start) begin
      m_pending = ref_div(DivOp, A, B);
      m_left    = ref_lat(DivOp, A, B);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_busy", {31'd0, busy}, {31'd0, m_left != 0});
      check("cyc_done", {31'd0, done}, {31'd0, m_left == 1});
      check("cyc_res", DivRes, (m_left == 1) ? m_pending : m_res);
    end
  end

  // Issue one op, optionally pulse a foreign start at cycle pulse_at, wait for done (bounded).
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                       input int pulse_at);
    int cnt;
    int dones;
    @(negedge clk);
    start = 1'b1; DivOp = op; A = a; B = b;
    cnt = 0;
    while (cnt < 40) begin
      @(negedge clk);
      cnt++;
      start = 1'b0; A = $urandom; B = $urandom; DivOp = 2'($urandom);
      if (pulse_at != 0 && cnt == pulse_at) begin
        start = 1'b1; A = 32'd9; B = 32'd3; DivOp = 2'b01;
      end
      if (done) break;
    end
    start = 1'b0;
    check({name, "_lat"}, 32'(cnt), 32'(exp_lat));
    check({name, "_res"}, DivRes, exp_res);
    dones = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (i == 0) check({name, "_hold"}, DivRes, exp_res);
    end
    check({name, "_extra_done"}, 32'(dones), 32'd0);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; DivOp = '0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_res", DivRes, 32'd0);

    // Pin the reference model with hand-computed values.
    check("model_div_neg", ref_div(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("model_rem_neg", ref_div(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("model_rem_ovf", ref_div(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    do_op("divu_100_7",   2'b01, 32'd100,       32'd7,         32'd14,        33, 0);
    do_op("div_m7_2",     2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 0);
    do_op("rem_m7_2",     2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 0);
    do_op("div_7_m2",     2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
    do_op("rem_7_m2",     2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         33, 0);
    do_op("divu_big_2",   2'b01, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 33, 0);
    do_op("div_5_0",      2'b00, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  0);
    do_op("remu_5_0",     2'b11, 32'd5,         32'd0,         32'd5,         1,  0);
    do_op("rem_m5_0",     2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1,  0);
    do_op("div_ovf",      2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
    do_op("rem_ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  0);
    do_op("divu_ovf",     2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, 0);
    do_op("ignored_start", 2'b01, 32'd100,      32'd7,         32'd14,        33, 10);

    // Mid-operation reset abort.
    @(negedge clk);
    start = 1'b1; DivOp = 2'b00; A = 32'd1000; B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_res", DivRes, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    do_op("remu_after_rst", 2'b11, 32'd1000, 32'd3, 32'd1, 33, 0);

    // Random traffic: start asserted freely, including while busy and in FIN.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      DivOp = 2'($urandom);
      case ($urandom_range(0, 7))
        0:       begin A = $urandom; B = 32'd0; end
        1:       begin A = 32'h8000_0000; B = 32'hFFFF_FFFF; end
        2:       begin A = $urandom_range(0, 50); B = $urandom_range(1, 9); end
        3:       begin A = 32'hFFFF_FFFF - $urandom_range(0, 50); B = 32'hFFFF_FFFF - $urandom_range(0, 9); end
        4:       begin A = $urandom; B = $urandom >> $urandom_range(0, 31); end
        default: begin A = $urandom; B = $urandom; end
      endcase
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
